// File: rtl/ibex_pkg.sv
// Shared types and constants for the RVFI trace buffer: the stored record,
// header word layout and serializer states.
package ibex_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] rd_wdata;
    logic [4:0]  rd_addr;
    logic        trap;
    logic        intr;
    logic [15:0] drop_cnt;
  } trace_rec_t;

  // Header word (W0) bit positions
  localparam int unsigned HDR_MARK_BIT = 31;
  localparam int unsigned HDR_TRAP_BIT = 30;
  localparam int unsigned HDR_INTR_BIT = 29;
  localparam int unsigned HDR_RD_LSB   = 24;
  localparam int unsigned HDR_RD_W     = 5;
  localparam int unsigned HDR_DROP_LSB = 0;
  localparam int unsigned HDR_DROP_W   = 16;

  typedef enum logic [2:0] {
    SER_IDLE = 3'd0,
    SER_W0   = 3'd1,
    SER_W1   = 3'd2,
    SER_W2   = 3'd3,
    SER_W3   = 3'd4
  } ser_state_e;

endpackage

// File: rtl/ibex_rvfi_trace_fifo.sv
// Record FIFO: storage, wrap-bit pointers, full/empty and occupancy level.
module ibex_rvfi_trace_fifo
  import ibex_pkg::*;
#(
  parameter int Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  trace_rec_t             push_data,
  input  logic                   pop,
  output trace_rec_t             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] level
);

  localparam int AW = $clog2(Depth);

  trace_rec_t  mem [Depth];
  logic [AW:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is deliberately left out of reset; pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// Captures RVFI retirements into a record FIFO and streams each record out
// as four 32-bit words with a valid/ready handshake.
module ibex_rvfi_trace_buffer
  import ibex_pkg::*;
#(
  parameter int Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   trace_en_i,
  input  logic                   rvfi_valid,
  input  logic [31:0]            rvfi_pc_rdata,
  input  logic [31:0]            rvfi_insn,
  input  logic [4:0]             rvfi_rd_addr,
  input  logic [31:0]            rvfi_rd_wdata,
  input  logic                   rvfi_trap,
  input  logic                   rvfi_intr,
  output logic                   trace_valid_o,
  input  logic                   trace_ready_i,
  output logic [31:0]            trace_data_o,
  output logic                   trace_last_o,
  output logic [$clog2(Depth):0] level_o,
  output logic [15:0]            drop_cnt_o
);

  localparam int LW = $clog2(Depth) + 1;
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  ser_state_e state_q, state_d;
  trace_rec_t wr_rec, head;
  logic       capture, pop, store, drop, full, empty;
  logic [31:0] hdr;

  assign capture = rvfi_valid && trace_en_i;
  assign pop     = (state_q == SER_W3) && trace_ready_i;
  // A pop on the same edge frees the slot, so a capture while full still fits.
  assign store   = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_comb begin
    wr_rec          = '0;
    wr_rec.pc       = rvfi_pc_rdata;
    wr_rec.insn     = rvfi_insn;
    wr_rec.rd_wdata = rvfi_rd_wdata;
    wr_rec.rd_addr  = rvfi_rd_addr;
    wr_rec.trap     = rvfi_trap;
    wr_rec.intr     = rvfi_intr;
    wr_rec.drop_cnt = drop_cnt_o;
  end

  ibex_rvfi_trace_fifo #(.Depth(Depth)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (store),
    .push_data (wr_rec),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_o <= '0;
    end else if (store) begin
      drop_cnt_o <= '0;
    end else if (drop && drop_cnt_o != 16'hFFFF) begin
      drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  // Looking at the incoming store lets W0 appear the cycle after capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SER_IDLE: if (!empty || store) state_d = SER_W0;
      SER_W0:   if (trace_ready_i) state_d = SER_W1;
      SER_W1:   if (trace_ready_i) state_d = SER_W2;
      SER_W2:   if (trace_ready_i) state_d = SER_W3;
      SER_W3:   if (trace_ready_i) state_d = (level_o != LVL_ONE || store) ? SER_W0 : SER_IDLE;
      default:  state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= SER_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    hdr                            = '0;
    hdr[HDR_MARK_BIT]              = 1'b1;
    hdr[HDR_TRAP_BIT]              = head.trap;
    hdr[HDR_INTR_BIT]              = head.intr;
    hdr[HDR_RD_LSB +: HDR_RD_W]    = head.rd_addr;
    hdr[HDR_DROP_LSB +: HDR_DROP_W] = head.drop_cnt;
  end

  // Outputs derive only from registered state and the FIFO head, so they
  // hold steady under backpressure and drop to zero the moment reset hits.
  always_comb begin
    trace_data_o = '0;
    case (state_q)
      SER_W0:  trace_data_o = hdr;
      SER_W1:  trace_data_o = head.pc;
      SER_W2:  trace_data_o = head.insn;
      SER_W3:  trace_data_o = head.rd_wdata;
      default: trace_data_o = '0;
    endcase
  end

  assign trace_valid_o = (state_q != SER_IDLE);
  assign trace_last_o  = (state_q == SER_W3);

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Directed bench for ibex_rvfi_trace_buffer (Depth=8).
module tb_ibex_rvfi_trace_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        trace_en, rvfi_valid, rvfi_trap, rvfi_intr, trace_ready;
  logic [31:0] rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata, trace_data;
  logic [4:0]  rvfi_rd_addr;
  logic        trace_valid, trace_last;
  logic [3:0]  level;
  logic [15:0] drop_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ibex_rvfi_trace_buffer #(.Depth(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .trace_en_i    (trace_en),
    .rvfi_valid    (rvfi_valid),
    .rvfi_pc_rdata (rvfi_pc_rdata),
    .rvfi_insn     (rvfi_insn),
    .rvfi_rd_addr  (rvfi_rd_addr),
    .rvfi_rd_wdata (rvfi_rd_wdata),
    .rvfi_trap     (rvfi_trap),
    .rvfi_intr     (rvfi_intr),
    .trace_valid_o (trace_valid),
    .trace_ready_i (trace_ready),
    .trace_data_o  (trace_data),
    .trace_last_o  (trace_last),
    .level_o       (level),
    .drop_cnt_o    (drop_cnt)
  );

  task automatic set_rec(input logic [31:0] pc, input logic [31:0] insn,
                         input logic [4:0] rd, input logic [31:0] wd);
    rvfi_pc_rdata = pc;
    rvfi_insn     = insn;
    rvfi_rd_addr  = rd;
    rvfi_rd_wdata = wd;
    rvfi_valid    = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    tests_run++;
    if (trace_valid !== 1'b0 || trace_last !== 1'b0 || trace_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs got valid=%b last=%b data=%h want 0/0/0", trace_valid, trace_last, trace_data);
    end
    tests_run++;
    if (level !== 4'd0 || drop_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_counts got level=%0d drop=%0d want 0/0", level, drop_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [31:0] exp [4];
    exp[0] = 32'h8100_0000; exp[1] = 32'h0000_0100;
    exp[2] = 32'h0010_0093; exp[3] = 32'h0000_0001;
    trace_ready = 1'b1;
    @(posedge clk); #1;
    set_rec(32'h0000_0100, 32'h0010_0093, 5'd1, 32'h1);
    tests_run++;
    if (trace_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_pre_valid got %b want 0", trace_valid);
    end
    @(posedge clk); #1;
    rvfi_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (trace_valid !== 1'b1 || trace_data !== exp[k] || trace_last !== (k == 3)) begin
        tests_failed++;
        $display("FAIL single_w%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 k, trace_valid, trace_data, trace_last, exp[k], (k == 3));
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (trace_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_post_valid got %b want 0", trace_valid);
    end
  endtask

  task automatic test_backpressure;
    trace_ready = 1'b1;
    set_rec(32'h0000_0200, 32'h0020_0113, 5'd2, 32'h0000_0400);
    @(posedge clk); #1;
    rvfi_valid = 1'b0;
    tests_run++;
    if (trace_data !== 32'h8200_0000) begin
      tests_failed++;
      $display("FAIL bp_w0 got %h want 82000000", trace_data);
    end
    @(posedge clk); #1;
    trace_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (trace_valid !== 1'b1 || trace_data !== 32'h0000_0200 || trace_last !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold%0d got v=%b d=%h l=%b want v=1 d=00000200 l=0",
                 k, trace_valid, trace_data, trace_last);
      end
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    trace_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (trace_data !== 32'h0020_0113 || trace_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_w2 got d=%h l=%b want 00200113 l=0", trace_data, trace_last);
    end
    @(posedge clk); #1;
    tests_run++;
    if (trace_data !== 32'h0000_0400 || trace_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_w3 got d=%h l=%b want 00000400 l=1", trace_data, trace_last);
    end
    @(posedge clk); #1;
    tests_run++;
    if (trace_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_post_valid got %b want 0", trace_valid);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] words [40];
    int n, cyc;
    trace_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      set_rec(32'h1000 + i, i, 5'd3, i);
      @(posedge clk); #1;
    end
    rvfi_valid = 1'b0;
    tests_run++;
    if (level !== 4'd8 || drop_cnt !== 16'd3) begin
      tests_failed++;
      $display("FAIL ovf_full got level=%0d drop=%0d want 8/3", level, drop_cnt);
    end
    trace_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 32 && cyc < 200) begin
      @(negedge clk);
      if (trace_valid && trace_ready) begin
        words[n] = trace_data;
        n++;
      end
      cyc++;
    end
    tests_run++;
    if (n !== 32) begin
      tests_failed++;
      $display("FAIL ovf_drain_words got %0d want 32", n);
    end
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (words[4*k] !== 32'h8300_0000 || words[4*k+1] !== 32'h1000 + k) begin
        tests_failed++;
        $display("FAIL ovf_rec%0d got hdr=%h pc=%h want hdr=83000000 pc=%h",
                 k, words[4*k], words[4*k+1], 32'h1000 + k);
      end
    end
    @(posedge clk); #1;
    tests_run++;
    if (level !== 4'd0 || drop_cnt !== 16'd3) begin
      tests_failed++;
      $display("FAIL ovf_drained got level=%0d drop=%0d want 0/3", level, drop_cnt);
    end
    set_rec(32'h2000, 32'h0, 5'd3, 32'h0);
    @(posedge clk); #1;
    rvfi_valid = 1'b0;
    tests_run++;
    if (trace_data !== 32'h8300_0003 || drop_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL ovf_12th got hdr=%h drop=%0d want 83000003/0", trace_data, drop_cnt);
    end
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (trace_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_post_valid got %b want 0", trace_valid);
    end
  endtask

  task automatic test_full_pop_capture;
    logic [31:0] words [40];
    int n, cyc;
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_rec(32'h3000 + i, 32'h0, 5'd4, 32'h0);
      @(posedge clk); #1;
    end
    rvfi_valid = 1'b0;
    tests_run++;
    if (level !== 4'd8) begin
      tests_failed++;
      $display("FAIL fpc_fill got level=%0d want 8", level);
    end
    trace_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (trace_last !== 1'b1 || trace_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL fpc_w3 got last=%b d=%h want 1/00000000", trace_last, trace_data);
    end
    set_rec(32'h4000, 32'h0, 5'd4, 32'h0);
    @(posedge clk); #1;
    rvfi_valid = 1'b0;
    trace_ready = 1'b0;
    tests_run++;
    if (level !== 4'd8 || drop_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL fpc_same_cycle got level=%0d drop=%0d want 8/0", level, drop_cnt);
    end
    tests_run++;
    if (trace_valid !== 1'b1 || trace_data !== 32'h8400_0000) begin
      tests_failed++;
      $display("FAIL fpc_next_hdr got v=%b d=%h want 1/84000000", trace_valid, trace_data);
    end
    trace_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 32 && cyc < 200) begin
      @(negedge clk);
      if (trace_valid && trace_ready) begin
        words[n] = trace_data;
        n++;
      end
      cyc++;
    end
    tests_run++;
    if (n !== 32 || words[1] !== 32'h3001 || words[29] !== 32'h4000) begin
      tests_failed++;
      $display("FAIL fpc_drain got n=%0d pc0=%h pc7=%h want 32/00003001/00004000", n, words[1], words[29]);
    end
    @(posedge clk); #1;
    tests_run++;
    if (level !== 4'd0 || trace_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fpc_empty got level=%0d v=%b want 0/0", level, trace_valid);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_rec(32'h5000 + i, 32'h6000 + i, 5'd5, 32'h0);
      @(posedge clk); #1;
    end
    rvfi_valid = 1'b0;
    trace_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (trace_data !== 32'h6000 || level !== 4'd5) begin
      tests_failed++;
      $display("FAIL rst_mid_w2 got d=%h level=%0d want 00006000/5", trace_data, level);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (trace_valid !== 1'b0 || trace_data !== 32'h0 || trace_last !== 1'b0 || level !== 4'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_async got v=%b d=%h l=%b level=%0d want 0/0/0/0",
               trace_valid, trace_data, trace_last, level);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (trace_valid !== 1'b0) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL rst_mid_quiet got %0d valid cycles want 0", seen);
    end
    @(posedge clk); #1;
    set_rec(32'h7000, 32'h0, 5'd5, 32'h0);
    @(posedge clk); #1;
    rvfi_valid = 1'b0;
    tests_run++;
    if (trace_valid !== 1'b1 || trace_data !== 32'h8500_0000) begin
      tests_failed++;
      $display("FAIL rst_mid_new got v=%b d=%h want 1/85000000", trace_valid, trace_data);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_trace_disable;
    trace_en = 1'b0;
    trace_ready = 1'b0;
    repeat (4) begin
      set_rec(32'h8000, 32'h0, 5'd6, 32'h0);
      @(posedge clk); #1;
      rvfi_valid = 1'b0;
      @(posedge clk); #1;
    end
    tests_run++;
    if (level !== 4'd0 || drop_cnt !== 16'd0 || trace_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL disable got level=%0d drop=%0d v=%b want 0/0/0", level, drop_cnt, trace_valid);
    end
    trace_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    trace_en = 1'b1;
    rvfi_valid = 1'b0;
    rvfi_pc_rdata = '0;
    rvfi_insn = '0;
    rvfi_rd_addr = '0;
    rvfi_rd_wdata = '0;
    rvfi_trap = 1'b0;
    rvfi_intr = 1'b0;
    trace_ready = 1'b0;
    test_reset;
    test_single;
    test_backpressure;
    test_overflow;
    test_full_pop_capture;
    test_reset_mid;
    test_trace_disable;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/ibex_rvfi_trace_buffer.md
IBEX_RVFI_TRACE_BUFFER -- requirements
Module: ibex_rvfi_trace_buffer

Interface
REQ-001 Parameter Depth, default 8, record capacity; power of two, >= 2.
REQ-002 clk_i  input  1  core clock; all state on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 trace_en_i  input  1  capture enable; 0 ignores rvfi_valid (no capture, no drop count).
REQ-005 rvfi_valid  input  1  one retired instruction this cycle.
REQ-006 rvfi_pc_rdata  input  32  retired PC.
REQ-007 rvfi_insn  input  32  retired instruction word.
REQ-008 rvfi_rd_addr  input  5  destination register.
REQ-009 rvfi_rd_wdata  input  32  destination write data.
REQ-010 rvfi_trap  input  1  trap flag.
REQ-011 rvfi_intr  input  1  first instruction of a handler.
REQ-012 trace_valid_o  output  1  trace_data_o holds a valid word.
REQ-013 trace_ready_i  input  1  sink accepts the word when high with trace_valid_o.
REQ-014 trace_data_o  output  32  serialized record word.
REQ-015 trace_last_o  output  1  high on the final word of a record.
REQ-016 level_o  output  $clog2(Depth)+1  stored records, including the one being serialized.
REQ-017 drop_cnt_o  output  16  records dropped since the last enqueue.

Function
REQ-018 Capture happens when rvfi_valid && trace_en_i.
- Not full: store {pc, insn, rd_wdata, rd_addr, trap, intr, drop_cnt} at the write pointer.
- Then clear drop_cnt to 0.
REQ-019 Capture while full drops the record.
- drop_cnt increments and saturates at 16'hFFFF.
- If the final word of the head record handshakes in that same cycle, the slot frees and the capture is stored, not dropped.
REQ-020 Record word order:
- W0 header: [31]=1, [30]=trap, [29]=intr, [28:24]=rd_addr, [23:16]=0, [15:0]=stored drop count.
- W1 = pc; W2 = insn; W3 = rd_wdata, with trace_last_o=1.
REQ-021 Serializer FSM states IDLE, W0, W1, W2, W3.
- IDLE->W0 when not empty.
- Wn->Wn+1 on handshake.
- W3 on handshake -> pop the record, then go to W0 if another record remains, else IDLE.
REQ-022 Latency: a record captured in cycle N drives trace_valid_o=1 with W0 in cycle N+1 when the buffer was empty; no bubble cycles between back-to-back records.
REQ-023 While trace_valid_o && !trace_ready_i, trace_data_o and trace_last_o hold stable.
REQ-024 Pointers are $clog2(Depth) bits plus a wrap bit.
- full = equal index with differing wrap bit; empty = equal pointers.
- Both pointers wrap modulo Depth.
REQ-025 level_o counts +1 on store, -1 on W3 handshake; simultaneous store and pop leaves it unchanged.
REQ-026 trace_en_i deasserting mid-record does not abort serialization; buffered records still drain.

Reset
REQ-027 On rst_i asserted, the block clears asynchronously:
- FSM=IDLE; pointers, level_o and drop_cnt_o = 0.
- trace_valid_o=0, trace_last_o=0, trace_data_o=0.
REQ-028 Reset mid-record discards all buffered records; no partial record is emitted after release.
REQ-029 Record storage array is not reset.

Structure
REQ-030 The following belong in ibex_pkg:
- trace record struct typedef;
- header bit-position constants;
- serializer state enum.
REQ-031 One sub-module: ibex_rvfi_trace_fifo (storage, pointers, full/empty, level); the serializer FSM and drop counter live in the top.

Verification
REQ-032 Single capture: pc=32'h0000_0100, insn=32'h0010_0093, rd=1, wdata=1.
- Response: words 32'h8100_0000, 32'h0000_0100, 32'h0010_0093, 32'h0000_0001 on consecutive cycles with ready=1; last only on word 4; first word at N+1.
REQ-033 Backpressure: ready low 3 cycles during W1.
- Response: W1 held stable; no word lost or duplicated.
REQ-034 Overflow, Depth=8, ready=0:
- Stimulus: 11 captures, then drain, then 1 capture.
- Response: level_o=8 and drop_cnt_o=3 before drain; the 12th record header [15:0]=3; drop_cnt_o then 0.
REQ-035 Full plus final-word handshake in same cycle as a capture.
- Response: capture stored; level_o stays 8; drop_cnt_o stays 0.
REQ-036 Reset asserted during W2 with 5 records buffered.
- Response: outputs 0 immediately; after release, trace_valid_o stays 0 until a new capture.
REQ-037 trace_en_i=0 with 4 rvfi_valid pulses.
- Response: level_o and drop_cnt_o remain 0.
